// File: rtl/pulse_window_scheduler.sv
// Sequences the photon counter into fixed windows, samples counts into a valid/ready FIFO and mirrors them to the LCD.
// Optional running sum on acc_o is built only when PWS_ACCUM_EN is defined.
module pulse_window_scheduler #(
    parameter int WINDOW_CYCLES = 80000,
    parameter int FIFO_DEPTH    = 8,
    parameter int DROP_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [27:0]       win_len_i,
    output logic              gate_o,
    output logic              clr_o,
    input  logic [31:0]       cnt_i,
    input  logic              ovf_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [39:0]       m_data,
    output logic [31:0]       lcd_data,
    output logic              lcd_upd,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy_o,
    output logic [31:0]       acc_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COUNT, S_LATCH} state_t;

    state_t              r_state;
    logic [27:0]         r_len;
    logic [27:0]         r_wcnt;
    logic                r_stop_pend;
    logic [6:0]          r_seq;
    logic                r_gate;
    logic                r_clr;
    logic                r_busy;
    logic                r_lcd_upd;
    logic [31:0]         r_lcd;
    logic [39:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [39:0]         r_last;
    logic [DROP_W-1:0]   r_drop;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_latch;
    logic                w_push;
    logic                w_drop;
    logic [39:0]         w_sample;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = !w_empty && m_ready;
    // A window aborted by en in its LATCH cycle is discarded like any other partial window.
    assign w_latch  = (r_state == S_LATCH) && en;
    assign w_push   = w_latch && (!w_full || w_pop);
    assign w_drop   = w_latch && w_full && !w_pop;
    assign w_sample = {ovf_i, r_seq, cnt_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_stop_pend <= 1'b0;
            r_seq       <= '0;
            r_gate      <= 1'b0;
            r_clr       <= 1'b0;
            r_busy      <= 1'b0;
            r_lcd_upd   <= 1'b0;
            r_lcd       <= '0;
        end else begin
            r_gate    <= 1'b0;
            r_clr     <= 1'b0;
            r_lcd_upd <= 1'b0;
            if (!en) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_stop_pend <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_state     <= S_CLEAR;
                            r_clr       <= 1'b1;
                            r_busy      <= 1'b1;
                            r_stop_pend <= stop_i;
                            r_len       <= (win_len_i == '0) ? 28'(WINDOW_CYCLES) : win_len_i;
                        end
                    end
                    S_CLEAR: begin
                        r_wcnt      <= '0;
                        r_gate      <= 1'b1;
                        r_state     <= S_COUNT;
                        r_stop_pend <= r_stop_pend | stop_i;
                    end
                    S_COUNT: begin
                        r_wcnt      <= r_wcnt + 28'd1;
                        r_stop_pend <= r_stop_pend | stop_i;
                        if (r_wcnt == r_len - 28'd1) begin
                            r_state <= S_LATCH;
                        end else begin
                            r_gate  <= 1'b1;
                        end
                    end
                    default: begin
                        r_seq       <= r_seq + 7'd1;
                        r_lcd       <= cnt_i;
                        r_lcd_upd   <= 1'b1;
                        r_stop_pend <= 1'b0;
                        if (r_stop_pend || stop_i) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_CLEAR;
                            r_clr   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_sample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    // Once drained, the output keeps showing the last popped entry rather than stale storage.
    assign m_valid  = !w_empty;
    assign m_data   = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
    assign gate_o   = r_gate;
    assign clr_o    = r_clr;
    assign busy_o   = r_busy;
    assign lcd_data = r_lcd;
    assign lcd_upd  = r_lcd_upd;
    assign drop_cnt = r_drop;

`ifdef PWS_ACCUM_EN
    logic [31:0] r_acc;
    logic [32:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, cnt_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_latch) begin
            r_acc <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
        end
    end

    assign acc_o = r_acc;
`else
    assign acc_o = '0;
`endif

endmodule

// File: tb/tb_pulse_window_scheduler.sv
// Directed bench for pulse_window_scheduler: window timing, FIFO fill/drop, stop/abort paths, accumulator.
module tb_pulse_window_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [27:0] win_len_i = '0;
    logic        gate_o;
    logic        clr_o;
    logic [31:0] cnt_i = '0;
    logic        ovf_i = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [39:0] m_data;
    logic [31:0] lcd_data;
    logic        lcd_upd;
    logic [15:0] drop_cnt;
    logic        busy_o;
    logic [31:0] acc_o;

    int tests = 0;
    int fails = 0;

    pulse_window_scheduler #(.WINDOW_CYCLES(40), .FIFO_DEPTH(8), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .start_i(start_i), .stop_i(stop_i),
        .win_len_i(win_len_i), .gate_o(gate_o), .clr_o(clr_o), .cnt_i(cnt_i),
        .ovf_i(ovf_i), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .lcd_data(lcd_data), .lcd_upd(lcd_upd), .drop_cnt(drop_cnt),
        .busy_o(busy_o), .acc_o(acc_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Starts one window (optionally with stop) and runs until busy drops, counting gate cycles.
    task automatic run_window(input logic [27:0] len, input logic stp, output int gates);
        bit done;
        done = 1'b0;
        gates = 0;
        start_i = 1'b1;
        stop_i = stp;
        win_len_i = len;
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
            gates += int'(gate_o);
            tick();
        end
        check("window_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        int p;
        int g;
        int upd;
        logic [31:0] exp_acc;

        // Reset state
        do_reset();
        check("rst_outputs", {gate_o, clr_o, busy_o, m_valid, lcd_upd}, 64'd0);
        check("rst_mdata", 64'(m_data), 64'd0);
        check("rst_lcd_drop_acc", {lcd_data, drop_cnt}, 64'd0);
        check("rst_acc", 64'(acc_o), 64'd0);

        // 1: basic window, len 10, period 12
        en = 1'b1; cnt_i = 32'd25; win_len_i = 28'd10; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t1_clr_first", {clr_o, gate_o, busy_o}, 64'b101);
        p = 0; g = 0; upd = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            p++;
            g += int'(gate_o);
            upd += int'(lcd_upd);
            if (clr_o) break;
        end
        check("t1_period", 64'(p), 64'd12);
        check("t1_gate_width", 64'(g), 64'd10);
        check("t1_lcd_upd_cnt", 64'(upd), 64'd1);
        check("t1_mdata", {m_valid, m_data}, {1'b1, 40'h00_0000_0019});
        check("t1_lcd_data", 64'(lcd_data), 64'd25);
        tick();
        check("t1_upd_clr_low", {lcd_upd, clr_o}, 64'd0);

        // 2: free-run into a stalled FIFO, 10 windows of len 4
        do_reset();
        en = 1'b1; m_ready = 1'b0; cnt_i = 32'h55; win_len_i = 28'd4; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (60) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        check("t2_abort_idle", {busy_o, gate_o, clr_o}, 64'd0);
        check("t2_drop_cnt", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", {m_valid, m_data}, {1'b1, 1'b0, i[6:0], 32'h55});
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        check("t2_empty_hold", {m_valid, m_data}, {1'b0, 1'b0, 7'd7, 32'h55});

        // 3a: start and stop together -> one window, busy drops after LATCH
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        repeat (5) tick();
        check("t3_latch_busy", {busy_o, gate_o}, 64'b10);
        tick();
        check("t3_idle_after", 64'(busy_o), 64'd0);
        check("t3_seq10", {m_valid, m_data}, {1'b1, 1'b0, 7'd10, 32'h55});
        repeat (3) tick();
        check("t3_no_rerun", {busy_o, clr_o}, 64'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t3_single_push", 64'(m_valid), 64'd0);

        // 3b: stop mid-COUNT, window completes untruncated
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        run_window(28'd0, 1'b0, g);
        check("t3b_gate_total", 64'(g + 3), 64'd4);
        check("t3b_seq11", {m_valid, m_data}, {1'b1, 1'b0, 7'd11, 32'h55});

        // 4: en low at cycle 5 of 10
        win_len_i = 28'd10; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        check("t4_counting", 64'(gate_o), 64'd1);
        en = 1'b0;
        tick();
        check("t4_abort", {gate_o, clr_o, busy_o}, 64'd0);
        en = 1'b1;
        check("t4_fifo_intact", {m_valid, m_data}, {1'b1, 1'b0, 7'd11, 32'h55});
        run_window(28'd2, 1'b1, g);
        m_ready = 1'b1;
        tick();
        check("t4_seq_unchanged", {m_valid, m_data}, {1'b1, 1'b0, 7'd12, 32'h55});
        tick();
        m_ready = 1'b0;
        check("t4_drained", 64'(m_valid), 64'd0);

        // 5: pop coincides with push on a full FIFO
        do_reset();
        en = 1'b1; cnt_i = 32'd7; win_len_i = 28'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (35) tick();
        check("t5_pre_drop", 64'(drop_cnt), 64'd0);
        m_ready = 1'b1; cnt_i = 32'h99;
        tick();
        m_ready = 1'b0; en = 1'b0;
        tick();
        en = 1'b1;
        check("t5_no_drop", 64'(drop_cnt), 64'd0);
        for (int i = 1; i < 9; i++) begin
            check("t5_drain", {m_valid, m_data},
                  {1'b1, 1'b0, i[6:0], (i == 8) ? 32'h99 : 32'd7});
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        check("t5_empty", 64'(m_valid), 64'd0);
        run_window(28'd0, 1'b1, g);
        check("t5_default_len", 64'(g), 64'd40);

        // 6: accumulator saturation (zero when the feature is not built)
        do_reset();
        en = 1'b1; m_ready = 1'b1;
        check("t6_acc_rst", 64'(acc_o), 64'd0);
        cnt_i = 32'hFFFF_FFF0;
        run_window(28'd2, 1'b1, g);
`ifdef PWS_ACCUM_EN
        exp_acc = 32'hFFFF_FFF0;
`else
        exp_acc = 32'd0;
`endif
        check("t6_acc_1", 64'(acc_o), 64'(exp_acc));
        cnt_i = 32'h20;
        run_window(28'd2, 1'b1, g);
`ifdef PWS_ACCUM_EN
        exp_acc = 32'hFFFF_FFFF;
`endif
        check("t6_acc_2", 64'(acc_o), 64'(exp_acc));
        cnt_i = 32'h5;
        run_window(28'd2, 1'b1, g);
        check("t6_acc_3", 64'(acc_o), 64'(exp_acc));
        en = 1'b0;
        tick();
        check("t6_acc_en_low", 64'(acc_o), 64'(exp_acc));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
